// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, request kinds and the encoder FIFO payload.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_ADDI = 4'd8,
    KIND_J    = 4'd9
  } kind_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers/count and a synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & (count_q < CW'(DEPTH));
  assign pop_ok  = pop_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into MIPS words, tags each with a
// sequential byte address and queues them for the instruction-memory loader.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] word_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned WC_W  = 16;

  logic              live_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  fifo_entry_t       wr_entry, rd_entry;
  logic [INSTR_W-1:0] instr_c;
  logic              kind_ok_c;
  logic              accept, push, pop;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [WC_W-1:0]   wc_q, wc_d;

  assign in_ready  = live_q & ~clear & (fifo_count < CNT_W'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign push      = accept & kind_ok_c;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Field packing per request kind; unused fields are ignored.
  always_comb begin
    instr_c   = '0;
    kind_ok_c = 1'b1;
    case (in_kind)
      KIND_ADD:  instr_c = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, F_ADD};
      KIND_SUB:  instr_c = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, F_SUB};
      KIND_AND:  instr_c = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, F_AND};
      KIND_OR:   instr_c = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, F_OR};
      KIND_SLT:  instr_c = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, F_SLT};
      KIND_LW:   instr_c = {OP_LW,   in_rs, in_rt, in_imm};
      KIND_SW:   instr_c = {OP_SW,   in_rs, in_rt, in_imm};
      KIND_BEQ:  instr_c = {OP_BEQ,  in_rs, in_rt, in_imm};
      KIND_ADDI: instr_c = {OP_ADDI, in_rs, in_rt, in_imm};
      KIND_J:    instr_c = {OP_J, in_target};
      default:   kind_ok_c = 1'b0;
    endcase
  end

  assign wr_entry.instr = instr_c;
  assign wr_entry.addr  = addr_q;

  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    wc_d   = wc_q;
    if (clear) begin
      addr_d = BASE_ADDR;
      err_d  = 1'b0;
      wc_d   = '0;
    end else begin
      if (push) begin
        addr_d = addr_q + ADDR_W'(4);
        if (wc_q != {WC_W{1'b1}}) wc_d = wc_q + WC_W'(1);
      end
      if (accept && !kind_ok_c) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q <= 1'b0;
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
      wc_q   <= '0;
    end else begin
      live_q <= 1'b1;
      addr_q <= addr_d;
      err_q  <= err_d;
      wc_q   <= wc_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Empty head shows the reset values rather than stale storage.
  assign out_instr  = fifo_empty ? '0 : rd_entry.instr;
  assign out_addr   = fifo_empty ? BASE_ADDR : rd_entry.addr;
  assign err        = err_q;
  assign word_count = wc_q;

endmodule
